// File: rtl/alu_seq_unit.sv
// Handshaked 16-function ALU with {Z,C,N,O} flags, full/half width and iterative shifts.
// Define ALU_MULTISHIFT_EN for k-bit shifts done one bit per cycle; otherwise every shift moves exactly 1 bit.
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FunSel,
  input  logic [SHW-1:0]   ShAmt,
  input  logic             WF,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  localparam int H = WIDTH / 2;

  localparam logic [3:0] OP_PASSA = 4'b0000;
  localparam logic [3:0] OP_PASSB = 4'b0001;
  localparam logic [3:0] OP_NOTA  = 4'b0010;
  localparam logic [3:0] OP_NOTB  = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_ADC   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_NAND  = 4'b1010;
  localparam logic [3:0] OP_LSL   = 4'b1011;
  localparam logic [3:0] OP_ASR   = 4'b1101;
  localparam logic [3:0] OP_CSL   = 4'b1110;

`ifdef ALU_MULTISHIFT_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_start_state;
  logic [WIDTH-1:0] r_alu_out;
  logic [3:0]       r_flags;

  logic [3:0]       w_op;
  logic             w_half;
  logic             w_is_shift;
  logic             w_is_sub;
  logic             w_is_arith;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_op;
  logic             w_cin;
  logic [WIDTH:0]   w_sum_f;
  logic [H:0]       w_sum_h;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_sa;
  logic             w_sb;
  logic             w_cout;
  logic             w_ovf;
  logic [3:0]       w_flags_alu;
  logic [WIDTH:0]   w_step;
  logic [WIDTH-1:0] w_step_res;
  logic [3:0]       w_flags_sh;

  // Low H bits sign-extended in half mode; full-width value passes through.
  function automatic logic [WIDTH-1:0] sext(input logic [WIDTH-1:0] v, input logic half);
    return half ? {{(WIDTH-H){v[H-1]}}, v[H-1:0]} : v;
  endfunction

  // One-bit shift step; returns {bit shifted out, new value}. Half mode keeps bits within H.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] v, input logic [3:0] op,
                                                input logic half, input logic cin);
    logic             msb;
    logic             fill;
    logic             s_out;
    logic [WIDTH-1:0] n;
    msb  = half ? v[H-1] : v[WIDTH-1];
    fill = 1'b0;
    if (op == OP_ASR)
      fill = msb;
    else if (op == OP_CSL || op == 4'b1111)
      fill = cin;
    if (op == OP_LSL || op == OP_CSL) begin
      n     = {v[WIDTH-2:0], fill};
      s_out = msb;
    end else begin
      n = {fill, v[WIDTH-1:1]};
      if (half)
        n[H-1] = fill;
      s_out = v[0];
    end
    return {s_out, n};
  endfunction

  assign w_op       = FunSel[3:0];
  assign w_half     = ~FunSel[4];
  assign w_is_shift = (w_op >= OP_LSL);
  assign w_is_sub   = (w_op == OP_SUB);
  assign w_is_arith = (w_op == OP_ADD) | (w_op == OP_ADC) | w_is_sub;
  assign w_accept   = InValid & InReady;

  assign w_b_op  = w_is_sub ? ~B : B;
  assign w_cin   = (w_op == OP_ADC) ? r_flags[2] : w_is_sub;
  assign w_sum_f = {1'b0, A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_cin};
  assign w_sum_h = {1'b0, A[H-1:0]} + {1'b0, w_b_op[H-1:0]} + {{H{1'b0}}, w_cin};

  always_comb begin
    w_raw = A;
    case (w_op)
      OP_PASSA: w_raw = A;
      OP_PASSB: w_raw = B;
      OP_NOTA:  w_raw = ~A;
      OP_NOTB:  w_raw = ~B;
      OP_ADD, OP_ADC, OP_SUB:
        w_raw = w_half ? {{(WIDTH-H){1'b0}}, w_sum_h[H-1:0]} : w_sum_f[WIDTH-1:0];
      OP_AND:   w_raw = A & B;
      OP_OR:    w_raw = A | B;
      OP_XOR:   w_raw = A ^ B;
      OP_NAND:  w_raw = ~(A & B);
      default:  w_raw = A;
    endcase
  end

  assign w_res  = sext(w_raw, w_half);
  assign w_sa   = w_half ? A[H-1] : A[WIDTH-1];
  assign w_sb   = w_half ? B[H-1] : B[WIDTH-1];
  assign w_cout = w_half ? w_sum_h[H] : w_sum_f[WIDTH];
  // Sub overflow compares against the original B sign, not the inverted operand.
  assign w_ovf  = w_is_sub ? ((w_sa != w_sb) && (w_res[WIDTH-1] == w_sb))
                           : ((w_sa == w_sb) && (w_res[WIDTH-1] != w_sa));
  assign w_flags_alu = {(w_res == '0), (w_is_arith ? w_cout : r_flags[2]), w_res[WIDTH-1],
                        (w_is_arith ? w_ovf : r_flags[0])};

`ifdef ALU_MULTISHIFT_EN
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic [3:0]       r_op;
  logic             r_half;
  logic             r_wf;
  logic             r_carry;
  logic [WIDTH-1:0] w_a_ext;

  assign w_step        = shift_step(r_work, r_op, r_half, r_carry);
  assign w_step_res    = sext(w_step[WIDTH-1:0], r_half);
  assign w_a_ext       = sext(A, w_half);
  assign w_start_state = (w_is_shift && (ShAmt != '0)) ? S_SHIFT : S_DONE;
`else
  logic w_unused;

  assign w_unused      = ^ShAmt;
  assign w_step        = shift_step(A, w_op, w_half, r_flags[2]);
  assign w_step_res    = sext(w_step[WIDTH-1:0], w_half);
  assign w_start_state = S_DONE;
`endif
  assign w_flags_sh = {(w_step_res == '0), w_step[WIDTH], w_step_res[WIDTH-1], r_flags[0]};

  always_ff @(posedge Clock) begin
    if (Reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept)
          w_state_next = w_start_state;
`ifdef ALU_MULTISHIFT_EN
      S_SHIFT:
        if (r_cnt == SHW'(1))
          w_state_next = S_DONE;
`endif
      S_DONE:
        if (w_accept)
          w_state_next = w_start_state;
        else if (OutReady)
          w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    InReady  = 1'b0;
    OutValid = 1'b0;
    case (r_state)
      S_IDLE: InReady = 1'b1;
      S_DONE: begin
        OutValid = 1'b1;
        InReady  = OutReady;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_alu_out <= '0;
      r_flags   <= 4'b0000;
`ifdef ALU_MULTISHIFT_EN
      r_work    <= '0;
      r_cnt     <= '0;
      r_op      <= 4'b0000;
      r_half    <= 1'b0;
      r_wf      <= 1'b0;
      r_carry   <= 1'b0;
`endif
    end else if (w_accept) begin
      if (!w_is_shift) begin
        r_alu_out <= w_res;
        if (WF)
          r_flags <= w_flags_alu;
      end else begin
`ifdef ALU_MULTISHIFT_EN
        r_carry <= r_flags[2];
        if (ShAmt != '0) begin
          r_work <= A;
          r_cnt  <= ShAmt;
          r_op   <= w_op;
          r_half <= w_half;
          r_wf   <= WF;
        end else begin
          r_alu_out <= w_a_ext;
          if (WF)
            r_flags <= {(w_a_ext == '0), r_flags[2], w_a_ext[WIDTH-1], r_flags[0]};
        end
`else
        r_alu_out <= w_step_res;
        if (WF)
          r_flags <= w_flags_sh;
`endif
      end
    end
`ifdef ALU_MULTISHIFT_EN
    else if (r_state == S_SHIFT) begin
      r_work  <= w_step[WIDTH-1:0];
      r_carry <= w_step[WIDTH];
      r_cnt   <= r_cnt - SHW'(1);
      if (r_cnt == SHW'(1)) begin
        r_alu_out <= w_step_res;
        if (r_wf)
          r_flags <= w_flags_sh;
      end
    end
`endif
  end

  assign ALUOut   = r_alu_out;
  assign FlagsOut = r_flags;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit at WIDTH=32; shift expectations follow ALU_MULTISHIFT_EN.
module tb_alu_seq_unit;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  fun_sel;
  logic [4:0]  sh_amt;
  logic        wf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic [3:0]  flags_out;
  int          n_cmp = 0;
  int          n_err = 0;

`ifdef ALU_MULTISHIFT_EN
  localparam logic [31:0] LSL_OUT  = 32'h0000_0010;
  localparam logic [3:0]  LSL_FLG  = 4'b0101;
  localparam logic [31:0] ZSH_OUT  = 32'h8000_0000;
  localparam logic [3:0]  ZSH_FLG  = 4'b0111;
  localparam logic [31:0] ASR_OUT  = 32'hFFFF_F003;
  localparam logic [3:0]  ASR_FLG  = 4'b0111;
`else
  localparam logic [31:0] LSL_OUT  = 32'hE000_0002;
  localparam logic [3:0]  LSL_FLG  = 4'b0111;
  localparam logic [31:0] ZSH_OUT  = 32'h4000_0000;
  localparam logic [3:0]  ZSH_FLG  = 4'b0001;
  localparam logic [31:0] ASR_OUT  = 32'hFFFF_C00E;
  localparam logic [3:0]  ASR_FLG  = 4'b0011;
`endif

  alu_seq_unit #(.WIDTH(32), .SHW(5)) dut (
    .Clock(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready),
    .A(a), .B(b), .FunSel(fun_sel), .ShAmt(sh_amt), .WF(wf),
    .OutValid(out_valid), .OutReady(out_ready), .ALUOut(alu_out), .FlagsOut(flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and returns 1 ns after the edge that accepted it.
  task automatic issue(input logic [4:0] fs, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] sh, input logic w, input bit keep);
    bit ok;
    fun_sel = fs; a = va; b = vb; sh_amt = sh; wf = w; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ok = (in_ready === 1'b1);
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!keep) in_valid = 1'b0;
    $display("op fun=%b a=%h b=%h sh=%0d wf=%b accepted=%0d", fs, va, vb, sh, w, ok);
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; fun_sel = '0; sh_amt = '0; wf = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    n_cmp++; if (alu_out !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h want 00000000", alu_out); end
    n_cmp++; if (flags_out !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags_out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_arith();
    idle_cycle();
    issue(5'b10100, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_cmp++; if (alu_out !== 32'h0) begin n_err++; $display("FAIL add_out: got %h want 00000000", alu_out); end
    n_cmp++; if (flags_out !== 4'b1100) begin n_err++; $display("FAIL add_flags: got %b want 1100", flags_out); end
    idle_cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_release: got %b want 0", out_valid); end
    issue(5'b10110, 32'h8000_0000, 32'h0000_0001, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (alu_out !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sub_out: got %h want 7fffffff", alu_out); end
    n_cmp++; if (flags_out !== 4'b0101) begin n_err++; $display("FAIL sub_flags: got %b want 0101", flags_out); end
    idle_cycle();
    issue(5'b00100, 32'h1234_7FFF, 32'h0000_0001, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (alu_out !== 32'hFFFF_8000) begin n_err++; $display("FAIL half_add_out: got %h want ffff8000", alu_out); end
    n_cmp++; if (flags_out !== 4'b0011) begin n_err++; $display("FAIL half_add_flags: got %b want 0011", flags_out); end
  endtask

  task automatic test_lsl();
    idle_cycle();
    issue(5'b11011, 32'hF000_0001, 32'h0, 5'd4, 1'b1, 1'b0);
`ifdef ALU_MULTISHIFT_EN
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_err++; $display("FAIL lsl_busy%0d: ready=%b valid=%b want 0/0", i, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
`endif
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lsl_valid: got %b want 1", out_valid); end
    n_cmp++; if (alu_out !== LSL_OUT) begin n_err++; $display("FAIL lsl_out: got %h want %h", alu_out, LSL_OUT); end
    n_cmp++; if (flags_out !== LSL_FLG) begin n_err++; $display("FAIL lsl_flags: got %b want %b", flags_out, LSL_FLG); end
  endtask

  task automatic test_hold();
    idle_cycle();
    out_ready = 1'b0;
    issue(5'b11001, 32'h0F0F_0F0F, 32'hFF00_FF00, 5'd0, 1'b0, 1'b0);
    fun_sel = 5'b10001; b = 32'h1234_5678; wf = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_out !== 32'hF00F_F00F || flags_out !== LSL_FLG) begin
        n_err++;
        $display("FAIL hold%0d: valid=%b ready=%b out=%h flags=%b want 1/0/f00ff00f/%b",
                 i, out_valid, in_ready, alu_out, flags_out, LSL_FLG);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("op fun=10001 b=12345678 accepted on OutReady rise");
    n_cmp++; if (alu_out !== 32'h1234_5678) begin n_err++; $display("FAIL hold_next_out: got %h want 12345678", alu_out); end
    n_cmp++; if (flags_out !== 4'b0101) begin n_err++; $display("FAIL hold_next_flags: got %b want 0101", flags_out); end
  endtask

  task automatic test_shift_edges();
    idle_cycle();
    issue(5'b11100, 32'h8000_0000, 32'h0, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL zsh_valid: got %b want 1", out_valid); end
    n_cmp++; if (alu_out !== ZSH_OUT) begin n_err++; $display("FAIL zsh_out: got %h want %h", alu_out, ZSH_OUT); end
    n_cmp++; if (flags_out !== ZSH_FLG) begin n_err++; $display("FAIL zsh_flags: got %b want %b", flags_out, ZSH_FLG); end
    idle_cycle();
    issue(5'b01101, 32'hABCD_801C, 32'h0, 5'd3, 1'b1, 1'b0);
`ifdef ALU_MULTISHIFT_EN
    repeat (3) @(posedge clk);
    #1;
`endif
    n_cmp++; if (alu_out !== ASR_OUT) begin n_err++; $display("FAIL asr_out: got %h want %h", alu_out, ASR_OUT); end
    n_cmp++; if (flags_out !== ASR_FLG) begin n_err++; $display("FAIL asr_flags: got %b want %b", flags_out, ASR_FLG); end
  endtask

  task automatic test_back_to_back();
    idle_cycle();
    issue(5'b10100, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b1, 1'b1);
    n_cmp++; if (flags_out !== 4'b1100) begin n_err++; $display("FAIL b2b_first_flags: got %b want 1100", flags_out); end
    fun_sel = 5'b10101; a = 32'h1; b = 32'h1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("op fun=10101 a=00000001 b=00000001 accepted back-to-back");
    n_cmp++; if (alu_out !== 32'h3) begin n_err++; $display("FAIL b2b_adc_out: got %h want 00000003", alu_out); end
    n_cmp++; if (flags_out !== 4'b0000) begin n_err++; $display("FAIL b2b_adc_flags: got %b want 0000", flags_out); end
  endtask

  task automatic test_csl_reset();
    issue(5'b10110, 32'h0, 32'h1, 5'd0, 1'b1, 1'b0);
    n_cmp++; if (flags_out !== 4'b0010) begin n_err++; $display("FAIL pre_sub_flags: got %b want 0010", flags_out); end
    issue(5'b11110, 32'h8000_0001, 32'h0, 5'd20, 1'b1, 1'b0);
`ifdef ALU_MULTISHIFT_EN
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL csl_busy: ready=%b valid=%b want 0/0", in_ready, out_valid); end
`else
    n_cmp++; if (alu_out !== 32'h2 || flags_out !== 4'b0100) begin n_err++; $display("FAIL csl_one: out=%h flags=%b want 00000002/0100", alu_out, flags_out); end
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    n_cmp++; if (flags_out !== 4'b0000) begin n_err++; $display("FAIL abort_flags: got %b want 0000", flags_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    n_cmp++; if (alu_out !== 32'h0) begin n_err++; $display("FAIL abort_out: got %h want 00000000", alu_out); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_lsl();
    test_hold();
    test_shift_edges();
    test_back_to_back();
    test_csl_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
